// File: rtl/lstm_cell_engine.sv
// lstm_cell_engine
// Computes one LSTM cell step over an N-beat streamed operand vector.
// The four gate pre-activations are accumulated at full precision. A
// fixed pipeline then walks PRE -> ACT -> CELL -> HOUT and presents
// the result in OUT until it is accepted.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      begin a step (sampled only in IDLE)
//   mode       0 = standard LSTM, 1 = coupled forget gate (f = 1 - i)
//   c_prev     previous cell state (latched at start)
//   bias       per-gate biases {o, g, f, i} (latched at start)
//   in_valid   operand beat valid
//   in_ready   operand beat ready (high only while accumulating)
//   x_in/h_in  vector elements for this beat
//   wx_in/wh_in per-gate weights {o, g, f, i} for this beat
//   out_valid  result valid
//   out_ready  result accepted
//   h_new/c_new step results
//   busy       high whenever the engine is not idle
module lstm_cell_engine #(
    parameter int WL   = 12,
    parameter int FRAC = 8,
    parameter int N    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic signed [WL-1:0] c_prev,
    input  logic [4*WL-1:0]      bias,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [WL-1:0] x_in,
    input  logic signed [WL-1:0] h_in,
    input  logic [4*WL-1:0]      wx_in,
    input  logic [4*WL-1:0]      wh_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [WL-1:0] h_new,
    output logic signed [WL-1:0] c_new,
    output logic                 busy
);

    // Accumulator: 2*WL product bits, +1 for the x/h pair, +clog2(N) for
    // the beats, +1 spare, so no overflow can occur.
    localparam int ACC_W = 2*WL + $clog2(N) + 2;
    // Common width for all intermediate sums before saturation.
    localparam int W2    = ACC_W + 1;
    // Activation working width: holds +/-2^FRAC plus headroom.
    localparam int AW    = WL + 2;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACCUM = 3'd1;
    localparam logic [2:0] S_PRE   = 3'd2;
    localparam logic [2:0] S_ACT   = 3'd3;
    localparam logic [2:0] S_CELL  = 3'd4;
    localparam logic [2:0] S_HOUT  = 3'd5;
    localparam logic [2:0] S_OUT   = 3'd6;

    localparam logic signed [W2-1:0] SAT_HI = W2'((1 << (WL-1)) - 1);
    localparam logic signed [W2-1:0] SAT_LO = ~SAT_HI;
    localparam logic signed [AW-1:0] A_ONE  = AW'(1 << FRAC);
    localparam logic signed [AW-1:0] A_HALF = AW'(1 << (FRAC-1));
    localparam logic signed [AW-1:0] A_MONE = -A_ONE;
    localparam logic signed [AW-1:0] A_ZERO = '0;

    function automatic logic signed [WL-1:0] sat_wl(input logic signed [W2-1:0] v);
        logic signed [W2-1:0] r;
        if (v > SAT_HI)      r = SAT_HI;
        else if (v < SAT_LO) r = SAT_LO;
        else                 r = v;
        return WL'(r);
    endfunction

    // Hard sigmoid: (p/4 + 0.5) clamped to [0, 1].
    function automatic logic signed [WL-1:0] hsig(input logic signed [WL-1:0] p);
        logic signed [AW-1:0] t;
        t = AW'(p >>> 2) + A_HALF;
        if (t < A_ZERO)     t = A_ZERO;
        else if (t > A_ONE) t = A_ONE;
        return WL'(t);
    endfunction

    // Hard tanh: p clamped to [-1, 1].
    function automatic logic signed [WL-1:0] htanh(input logic signed [WL-1:0] p);
        logic signed [AW-1:0] t;
        t = AW'(p);
        if (t < A_MONE)     t = A_MONE;
        else if (t > A_ONE) t = A_ONE;
        return WL'(t);
    endfunction

    logic [2:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    mode_q, mode_d;
    logic signed [WL-1:0]    cprev_q, cprev_d;
    logic [4*WL-1:0]         bias_q, bias_d;
    logic signed [ACC_W-1:0] acc_q [4];
    logic signed [ACC_W-1:0] acc_d [4];
    logic signed [WL-1:0]    pre_q [4];
    logic signed [WL-1:0]    pre_d [4];
    logic signed [WL-1:0]    i_q, i_d, f_q, f_d, g_q, g_d, o_q, o_d;
    logic signed [WL-1:0]    c_q, c_d, h_q, h_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        cprev_d = cprev_q;
        bias_d  = bias_q;
        acc_d   = acc_q;
        pre_d   = pre_q;
        i_d     = i_q;
        f_d     = f_q;
        g_d     = g_q;
        o_d     = o_q;
        c_d     = c_q;
        h_d     = h_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    cnt_d   = '0;
                    mode_d  = mode;
                    cprev_d = c_prev;
                    bias_d  = bias;
                    for (int g = 0; g < 4; g++) acc_d[g] = '0;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    for (int g = 0; g < 4; g++) begin
                        acc_d[g] = acc_q[g]
                            + ACC_W'(x_in) * ACC_W'($signed(wx_in[g*WL +: WL]))
                            + ACC_W'(h_in) * ACC_W'($signed(wh_in[g*WL +: WL]));
                    end
                    if (cnt_q == CNT_W'(N-1)) state_d = S_PRE;
                    else                      cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_PRE: begin
                for (int g = 0; g < 4; g++) begin
                    pre_d[g] = sat_wl(W2'(acc_q[g] >>> FRAC)
                                      + W2'($signed(bias_q[g*WL +: WL])));
                end
                state_d = S_ACT;
            end
            S_ACT: begin
                i_d = hsig(pre_q[0]);
                f_d = mode_q ? WL'(A_ONE - AW'(hsig(pre_q[0]))) : hsig(pre_q[1]);
                g_d = htanh(pre_q[2]);
                o_d = hsig(pre_q[3]);
                state_d = S_CELL;
            end
            S_CELL: begin
                c_d = sat_wl(((W2'(f_q) * W2'(cprev_q)) >>> FRAC)
                             + ((W2'(i_q) * W2'(g_q)) >>> FRAC));
                state_d = S_HOUT;
            end
            S_HOUT: begin
                h_d = sat_wl((W2'(o_q) * W2'(htanh(c_q))) >>> FRAC);
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            cprev_q <= '0;
            bias_q  <= '0;
            for (int g = 0; g < 4; g++) begin
                acc_q[g] <= '0;
                pre_q[g] <= '0;
            end
            i_q <= '0;
            f_q <= '0;
            g_q <= '0;
            o_q <= '0;
            c_q <= '0;
            h_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            cprev_q <= cprev_d;
            bias_q  <= bias_d;
            acc_q   <= acc_d;
            pre_q   <= pre_d;
            i_q     <= i_d;
            f_q     <= f_d;
            g_q     <= g_d;
            o_q     <= o_d;
            c_q     <= c_d;
            h_q     <= h_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign h_new     = h_q;
    assign c_new     = c_q;

endmodule
